// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: 4-wide circular buffer with back-pressure and flush.
// Optional performance counters are enabled with `define FETCH_BUFFER_PERF_EN.
module fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [2:0]           in_valid_number,
    input  logic [3:0][31:0]     in_pc,
    input  logic [3:0][31:0]     in_inst,
    input  logic [3:0]           in_pred_taken,
    input  logic [3:0][31:0]     in_pred_pc,
    output logic                 stall_fetch,
    output logic [3:0]           out_valid,
    output logic [3:0][31:0]     out_pc,
    output logic [3:0][31:0]     out_inst,
    output logic [3:0]           out_pred_taken,
    output logic [3:0][31:0]     out_pred_pc,
    input  logic [2:0]           dec_pop_num,
    output logic [PTR_W:0]       count
`ifdef FETCH_BUFFER_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_empty_cycles
`endif
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W:0]   head_r;
    logic [PTR_W:0]   tail_r;
    logic [PTR_W:0]   count_r;

    logic [31:0]      pc_mem_r    [DEPTH];
    logic [31:0]      inst_mem_r  [DEPTH];
    logic             taken_mem_r [DEPTH];
    logic [31:0]      ppc_mem_r   [DEPTH];

    logic [2:0]       in_num_s;
    logic [2:0]       pop_req_s;
    logic [2:0]       push_n_s;
    logic [2:0]       pop_n_s;
    logic [PTR_W-1:0] wr_idx_s [4];
    logic [PTR_W-1:0] rd_idx_s [4];

    // Stall only depends on registered occupancy, so decode has no comb path to fetch.
    assign stall_fetch = (count_r > CNT_W'(DEPTH - 4));
    assign count       = count_r;

    // Clamp requested lane counts and derive the effective push/pop amounts.
    always_comb begin
        in_num_s  = 3'd4;
        pop_req_s = 3'd4;
        push_n_s  = 3'd0;
        pop_n_s   = 3'd0;
        if (in_valid_number < 3'd4) begin
            in_num_s = in_valid_number;
        end else begin
            in_num_s = 3'd4;
        end
        if (dec_pop_num < 3'd4) begin
            pop_req_s = dec_pop_num;
        end else begin
            pop_req_s = 3'd4;
        end
        if (flush || stall_fetch) begin
            push_n_s = 3'd0;
        end else begin
            push_n_s = in_num_s;
        end
        if (flush) begin
            pop_n_s = 3'd0;
        end else if (CNT_W'(pop_req_s) > count_r) begin
            pop_n_s = count_r[2:0];
        end else begin
            pop_n_s = pop_req_s;
        end
    end

    // Ring indices for the four write lanes and the four read lanes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_idx_s[i] = PTR_W'(tail_r + CNT_W'(i));
            rd_idx_s[i] = PTR_W'(head_r + CNT_W'(i));
        end
    end

    // Pointer and occupancy registers; flush clears everything and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {CNT_W{1'b0}};
            tail_r  <= {CNT_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {CNT_W{1'b0}};
            tail_r  <= {CNT_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_r + CNT_W'(pop_n_s);
            tail_r  <= tail_r + CNT_W'(push_n_s);
            count_r <= count_r + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
        end
    end

    // Entry storage; intentionally not reset, only lanes below push_n are written.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < push_n_s) begin
                pc_mem_r[wr_idx_s[k]]    <= in_pc[k];
                inst_mem_r[wr_idx_s[k]]  <= in_inst[k];
                taken_mem_r[wr_idx_s[k]] <= in_pred_taken[k];
                ppc_mem_r[wr_idx_s[k]]   <= in_pred_pc[k];
            end
        end
    end

    // Present the oldest four entries in program order.
    always_comb begin
        out_valid      = 4'b0000;
        out_pc         = '{default: 32'h0000_0000};
        out_inst       = '{default: 32'h0000_0000};
        out_pred_taken = 4'b0000;
        out_pred_pc    = '{default: 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            out_valid[i]      = (count_r > CNT_W'(i));
            out_pc[i]         = pc_mem_r[rd_idx_s[i]];
            out_inst[i]       = inst_mem_r[rd_idx_s[i]];
            out_pred_taken[i] = taken_mem_r[rd_idx_s[i]];
            out_pred_pc[i]    = ppc_mem_r[rd_idx_s[i]];
        end
    end

`ifdef FETCH_BUFFER_PERF_EN
    // Saturating stall/empty cycle counters; survive flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= 32'h0000_0000;
            perf_empty_cycles <= 32'h0000_0000;
        end else begin
            if (stall_fetch && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if ((count_r == {CNT_W{1'b0}}) && (perf_empty_cycles != 32'hFFFF_FFFF)) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_fetch_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        tk;
        logic [31:0] ppc;
    } ent_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [2:0]       in_valid_number;
    logic [3:0][31:0] in_pc;
    logic [3:0][31:0] in_inst;
    logic [3:0]       in_pred_taken;
    logic [3:0][31:0] in_pred_pc;
    logic             stall_fetch;
    logic [3:0]       out_valid;
    logic [3:0][31:0] out_pc;
    logic [3:0][31:0] out_inst;
    logic [3:0]       out_pred_taken;
    logic [3:0][31:0] out_pred_pc;
    logic [2:0]       dec_pop_num;
    logic [PTR_W:0]   count;
`ifdef FETCH_BUFFER_PERF_EN
    logic [31:0]      perf_stall_cycles;
    logic [31:0]      perf_empty_cycles;
`endif

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid_number(in_valid_number), .in_pc(in_pc), .in_inst(in_inst),
        .in_pred_taken(in_pred_taken), .in_pred_pc(in_pred_pc),
        .stall_fetch(stall_fetch), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_pred_taken(out_pred_taken), .out_pred_pc(out_pred_pc),
        .dec_pop_num(dec_pop_num), .count(count)
`ifdef FETCH_BUFFER_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    ent_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length, outputs are its first four entries.
    always @(posedge clk or negedge rst_n) begin
        int sz;
        int pn;
        int nn;
        ent_t e;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            sz = q.size();
            pn = (int'(dec_pop_num) < sz) ? int'(dec_pop_num) : sz;
            nn = (in_valid_number > 3'd4) ? 4 : int'(in_valid_number);
            for (int i = 0; i < pn; i++) void'(q.pop_front());
            if (sz <= DEPTH - 4) begin
                for (int k = 0; k < nn; k++) begin
                    e.pc = in_pc[k]; e.inst = in_inst[k];
                    e.tk = in_pred_taken[k]; e.ppc = in_pred_pc[k];
                    q.push_back(e);
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] ev;
        if (chk_en) begin
            ev = 4'b0000;
            for (int i = 0; i < 4; i++) ev[i] = (i < q.size());
            chk("count", 32'(count), 32'(q.size()));
            chk("stall_fetch", 32'(stall_fetch), 32'(q.size() > DEPTH - 4));
            chk("out_valid", 32'(out_valid), 32'(ev));
            for (int i = 0; i < 4; i++) begin
                if (i < q.size()) begin
                    chk("out_pc", out_pc[i], q[i].pc);
                    chk("out_inst", out_inst[i], q[i].inst);
                    chk("out_pred_taken", 32'(out_pred_taken[i]), 32'(q[i].tk));
                    chk("out_pred_pc", out_pred_pc[i], q[i].ppc);
                end
            end
        end
    end

    // Drive one cycle of stimulus from a negedge and return at the next negedge.
    task automatic cyc(input int n, input logic [31:0] base, input int pop, input logic fl);
        in_valid_number = 3'(n);
        for (int k = 0; k < 4; k++) begin
            in_pc[k]         = base + 32'(4 * k);
            in_inst[k]       = $urandom;
            in_pred_taken[k] = 1'($urandom);
            in_pred_pc[k]    = $urandom;
        end
        dec_pop_num = 3'(pop);
        flush       = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] seq;
        logic [31:0] hp;
        int          pn;
        bit          acc;
        rst_n = 1'b0; flush = 1'b0; in_valid_number = 3'd0; dec_pop_num = 3'd0;
        in_pc = '0; in_inst = '0; in_pred_taken = 4'b0000; in_pred_pc = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_fetch), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Four-lane push becomes visible one cycle later.
        cyc(4, 32'h1000, 0, 1'b0);
        chk("tp1_count", 32'(count), 32'd4);
        chk("tp1_valid", 32'(out_valid), 32'hF);
        chk("tp1_pc0", out_pc[0], 32'h1000);
        chk("tp1_pc3", out_pc[3], 32'h100C);

        // Partial packet: following packet lands directly behind lane 1.
        cyc(2, 32'h2000, 0, 1'b0);
        chk("tp2_count", 32'(count), 32'd6);
        cyc(0, 32'h0, 4, 1'b0);
        chk("tp2_count_pop", 32'(count), 32'd2);
        chk("tp2_pc0", out_pc[0], 32'h2000);
        chk("tp2_pc1", out_pc[1], 32'h2004);
        chk("tp2_valid", 32'(out_valid), 32'h3);
        cyc(4, 32'h5000, 0, 1'b0);
        chk("tp2_pc2", out_pc[2], 32'h5000);

        // Full boundary.
        cyc(4, 32'h0, 0, 1'b1);
        chk("tp3_flushed", 32'(count), 32'd0);
        for (int j = 0; j < 3; j++) cyc(4, 32'h4000 + 32'(16 * j), 0, 1'b0);
        chk("tp3_count12", 32'(count), 32'd12);
        chk("tp3_stall12", 32'(stall_fetch), 32'd0);
        cyc(4, 32'h4030, 0, 1'b0);
        chk("tp3_count16", 32'(count), 32'd16);
        chk("tp3_stall16", 32'(stall_fetch), 32'd1);
        cyc(4, 32'h4040, 0, 1'b0);
        chk("tp3_hold16", 32'(count), 32'd16);

        // Pop clamped to occupancy.
        cyc(0, 32'h0, 0, 1'b1);
        cyc(2, 32'h6000, 0, 1'b0);
        cyc(0, 32'h0, 4, 1'b0);
        chk("tp6_clamp", 32'(count), 32'd0);
        chk("tp6_valid", 32'(out_valid), 32'd0);
        cyc(0, 32'h0, 2, 1'b0);
        chk("tp6_empty_pop", 32'(count), 32'd0);

        // Flush beats simultaneous push and pop.
        cyc(4, 32'h7000, 0, 1'b0);
        cyc(1, 32'h7010, 0, 1'b0);
        chk("tp5_count5", 32'(count), 32'd5);
        cyc(4, 32'h7100, 4, 1'b1);
        chk("tp5_count", 32'(count), 32'd0);
        chk("tp5_valid", 32'(out_valid), 32'd0);
        chk("tp5_stall", 32'(stall_fetch), 32'd0);
        cyc(1, 32'h3000, 0, 1'b0);
        chk("tp5_pc0", out_pc[0], 32'h3000);

        // Streaming push 4 / pop 3 across pointer wrap; fetch re-offers the same pc when stalled.
        cyc(0, 32'h0, 0, 1'b1);
        seq = 32'h8000;
        hp  = 32'h8000;
        for (int j = 0; j < 40; j++) begin
            acc = (q.size() <= DEPTH - 4);
            pn  = (q.size() < 3) ? q.size() : 3;
            cyc(4, seq, 3, 1'b0);
            if (acc) seq += 32'd16;
            hp += 32'(4 * pn);
            if (count != '0) chk("tp4_seq_pc0", out_pc[0], hp);
        end

        // Random traffic, including clamped lane counts and occasional flushes.
        for (int j = 0; j < 400; j++) begin
            cyc($urandom_range(0, 7), $urandom, $urandom_range(0, 4), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset mid-cycle.
        cyc(0, 32'h0, 0, 1'b1);
        cyc(4, 32'hA000, 0, 1'b0);
        cyc(4, 32'hA010, 0, 1'b0);
        cyc(1, 32'hA020, 0, 1'b0);
        chk("tp6_count9", 32'(count), 32'd9);
        in_valid_number = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_stall", 32'(stall_fetch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4, 32'hB000, 0, 1'b0);
        chk("post_rst_pc0", out_pc[0], 32'hB000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
